// File: rtl/sudoku_pkg.sv
// Shared constants and types for the sudoku solver front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
//   CELLS/DIGITS/GRID_W : grid geometry; CNT_W : cell counter width
//   loaderState_t       : loader sequencing states
//   RES_*               : result codes reported with the drained grid
package sudoku_pkg;

  localparam int CELLS  = 81;
  localparam int DIGITS = 9;
  localparam int GRID_W = CELLS * DIGITS;
  localparam int CNT_W  = $clog2(CELLS);

  localparam logic [CNT_W-1:0] LAST_CELL = CNT_W'(CELLS - 1);

  typedef enum logic [2:0] {
    LOAD,
    CLR,
    START,
    WAIT,
    DRAIN
  } loaderState_t;

  typedef logic [1:0] resultCode_t;

  localparam resultCode_t RES_SOLVED  = 2'd0;
  localparam resultCode_t RES_TIMEOUT = 2'd1;
  localparam resultCode_t RES_ERROR   = 2'd2;
  localparam resultCode_t RES_WDOG    = 2'd3;

endpackage

// File: rtl/sudoku_cell_codec.sv
// Cell codec: digit -> 9-bit candidate mask, and candidate mask -> digit.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
//   digit        in  4 : 0 empty, 1..9 given, 10..15 illegal
//   cellEnc      out 9 : one-hot for 1..9, all ones for empty/illegal
//   digitIllegal out 1 : digit outside 0..9
//   cellIn       in  9 : candidate mask to decode
//   digitDec     out 4 : b+1 when exactly bit b is set, else 0
module sudoku_cell_codec
  import sudoku_pkg::*;
(
  input  logic [3:0]        digit,
  output logic [DIGITS-1:0] cellEnc,
  output logic              digitIllegal,
  input  logic [DIGITS-1:0] cellIn,
  output logic [3:0]        digitDec
);

  logic isOneHot;

  always_comb begin
    cellEnc      = '1;
    digitIllegal = (digit > 4'd9);
    if (digit >= 4'd1 && digit <= 4'd9) begin
      cellEnc = DIGITS'(1) << (digit - 4'd1);
    end
  end

  // Clearing the lowest set bit leaves zero only for a single-bit mask.
  assign isOneHot = (cellIn != '0) && ((cellIn & (cellIn - DIGITS'(1))) == '0);

  always_comb begin
    digitDec = 4'd0;
    if (isOneHot) begin
      for (int b = 0; b < DIGITS; b++) begin
        if (cellIn[b]) digitDec = 4'(b + 1);
      end
    end
  end

endmodule

// File: rtl/sudoku_grid_loader.sv
// Loads an 81-digit puzzle into the solver grid, runs the solver, drains the result.
// Latency: 2 cycles after the last input digit to start, completion +1 cycle to first output digit.
// Backpressure: in_ready only in LOAD; out_valid held with stable digit until out_ready.
//   clk/rst                         : clock, synchronous active-high reset
//   in_valid/in_ready/in_digit      : puzzle digit stream, cell 0 first
//   sol_*                           : solver grid, clr/start pulses, completion status
//   out_valid/out_ready/out_digit/out_last : solved digit stream
//   result/unsolved/bad_input/busy  : status
module sudoku_grid_loader
  import sudoku_pkg::*;
#(
  parameter int WDOG_CYC = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_digit,
  output logic [GRID_W-1:0] sol_in_grid,
  output logic              sol_clr,
  output logic              sol_start,
  input  logic [GRID_W-1:0] sol_out_grid,
  input  logic              sol_done,
  input  logic              sol_timeout,
  input  logic              sol_error,
  input  logic [6:0]        sol_unsolved,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [3:0]        out_digit,
  output logic              out_last,
  output logic [1:0]        result,
  output logic [6:0]        unsolved,
  output logic              bad_input,
  output logic              busy
);

  loaderState_t      state;
  logic [CNT_W-1:0]  cnt;
  logic [DIGITS-1:0] grid     [CELLS];
  logic [DIGITS-1:0] snapshot [CELLS];
  logic [31:0]       wdog;

  logic        inReadyR, solClrR, solStartR, outValidR, busyR, badInputR;
  resultCode_t resultR;
  logic [6:0]  unsolvedR;

  logic [DIGITS-1:0] wrCell;
  logic              wrIllegal;
  logic [3:0]        rdDigit;
  logic [3:0]        unusedWrDec;
  logic [DIGITS-1:0] unusedRdEnc;
  logic              unusedRdIllegal;

  logic        inXfer, outXfer, wdogHit, anyDone;
  resultCode_t doneCode;

  sudoku_cell_codec wrCodec (
    .digit       (in_digit),
    .cellEnc     (wrCell),
    .digitIllegal(wrIllegal),
    .cellIn      ('0),
    .digitDec    (unusedWrDec)
  );

  sudoku_cell_codec rdCodec (
    .digit       (4'd0),
    .cellEnc     (unusedRdEnc),
    .digitIllegal(unusedRdIllegal),
    .cellIn      (snapshot[cnt]),
    .digitDec    (rdDigit)
  );

  // inReadyR/outValidR are only ever set in LOAD/DRAIN, so they also gate by state.
  assign inXfer  = inReadyR & in_valid;
  assign outXfer = outValidR & out_ready;
  assign wdogHit = (WDOG_CYC != 0) && (wdog == 32'(WDOG_CYC - 1));
  assign anyDone = sol_error | sol_timeout | sol_done | wdogHit;

  always_comb begin
    doneCode = RES_WDOG;
    if (sol_error)        doneCode = RES_ERROR;
    else if (sol_timeout) doneCode = RES_TIMEOUT;
    else if (sol_done)    doneCode = RES_SOLVED;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= LOAD;
      cnt       <= '0;
      wdog      <= '0;
      inReadyR  <= 1'b0;
      solClrR   <= 1'b0;
      solStartR <= 1'b0;
      outValidR <= 1'b0;
      busyR     <= 1'b0;
      badInputR <= 1'b0;
      resultR   <= RES_SOLVED;
      unsolvedR <= '0;
      for (int k = 0; k < CELLS; k++) begin
        grid[k]     <= '1;
        snapshot[k] <= '0;
      end
    end else begin
      case (state)
        LOAD: begin
          inReadyR <= 1'b1;
          if (inXfer) begin
            grid[cnt] <= wrCell;
            // The first digit of a load restarts the sticky flag.
            badInputR <= (cnt == '0) ? wrIllegal : (badInputR | wrIllegal);
            if (cnt == LAST_CELL) begin
              state    <= CLR;
              cnt      <= '0;
              inReadyR <= 1'b0;
              solClrR  <= 1'b1;
              busyR    <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        CLR: begin
          solClrR   <= 1'b0;
          solStartR <= 1'b1;
          state     <= START;
        end
        START: begin
          solStartR <= 1'b0;
          wdog      <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          wdog <= wdog + 32'd1;
          if (anyDone) begin
            state     <= DRAIN;
            busyR     <= 1'b0;
            outValidR <= 1'b1;
            resultR   <= doneCode;
            unsolvedR <= sol_unsolved;
            for (int k = 0; k < CELLS; k++) begin
              snapshot[k] <= sol_out_grid[k*DIGITS +: DIGITS];
            end
          end
        end
        DRAIN: begin
          if (outXfer) begin
            if (cnt == LAST_CELL) begin
              state     <= LOAD;
              cnt       <= '0;
              outValidR <= 1'b0;
              inReadyR  <= 1'b1;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

  for (genvar k = 0; k < CELLS; k++) begin : gPack
    assign sol_in_grid[k*DIGITS +: DIGITS] = grid[k];
  end

  assign in_ready  = inReadyR;
  assign sol_clr   = solClrR;
  assign sol_start = solStartR;
  assign out_valid = outValidR;
  assign out_digit = outValidR ? rdDigit : 4'd0;
  assign out_last  = outValidR && (cnt == LAST_CELL);
  assign result    = resultR;
  assign unsolved  = unsolvedR;
  assign bad_input = badInputR;
  assign busy      = busyR;

endmodule

// File: tb/tb_sudoku_grid_loader.sv
// Scoreboard bench for sudoku_grid_loader with a behavioural solver responder.
// Latency: n/a.
// Backpressure: out_ready driven always-on, toggling or random per transaction.
module tb_sudoku_grid_loader;

  localparam int NC = 81;
  localparam int GW = 729;
  localparam int WD = 16;

  typedef struct {
    logic [GW-1:0] grid;
    logic [6:0]    uns;
    bit            err;
    bit            to;
    bit            done;
    bit            none;
    int            delay;
  } scen_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [3:0]    in_digit;
  logic [GW-1:0] sol_in_grid;
  logic          sol_clr;
  logic          sol_start;
  logic [GW-1:0] sol_out_grid;
  logic          sol_done;
  logic          sol_timeout;
  logic          sol_error;
  logic [6:0]    sol_unsolved;
  logic          out_valid;
  logic          out_ready;
  logic [3:0]    out_digit;
  logic          out_last;
  logic [1:0]    result;
  logic [6:0]    unsolved;
  logic          bad_input;
  logic          busy;

  always #5 clk = ~clk;

  sudoku_grid_loader #(.WDOG_CYC(WD)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_digit(in_digit),
    .sol_in_grid(sol_in_grid), .sol_clr(sol_clr), .sol_start(sol_start),
    .sol_out_grid(sol_out_grid), .sol_done(sol_done), .sol_timeout(sol_timeout),
    .sol_error(sol_error), .sol_unsolved(sol_unsolved),
    .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
    .out_last(out_last), .result(result), .unsolved(unsolved),
    .bad_input(bad_input), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  logic [GW-1:0] expGrid[$];
  int            expDig[$];
  int            expRes[$];
  int            expUns[$];
  scen_t         scenQ[$];
  int            readyMode = 0;
  int            drainIdx = 0;

  int    digs[NC];
  scen_t sc;

  task automatic checkInt(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic checkGrid(input string name, input logic [GW-1:0] act, input logic [GW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: a given digit leaves one candidate, anything else leaves all nine.
  function automatic logic [8:0] encCell(input int d);
    if (d >= 1 && d <= 9) return 9'(1) << (d - 1);
    return 9'h1FF;
  endfunction

  function automatic int decCell(input logic [8:0] c);
    int n = 0;
    int pos = 0;
    for (int b = 0; b < 9; b++) begin
      if (c[b]) begin
        n++;
        pos = b + 1;
      end
    end
    return (n == 1) ? pos : 0;
  endfunction

  function automatic logic [GW-1:0] cyclicGrid();
    logic [GW-1:0] g = '0;
    for (int k = 0; k < NC; k++) g[k*9 +: 9] = encCell(k % 9 + 1);
    return g;
  endfunction

  function automatic logic [GW-1:0] rndSolGrid();
    logic [GW-1:0] g = '0;
    for (int k = 0; k < NC; k++) begin
      if ($urandom_range(0, 4) == 0) g[k*9 +: 9] = 9'($urandom_range(0, 511));
      else                           g[k*9 +: 9] = encCell(int'($urandom_range(1, 9)));
    end
    return g;
  endfunction

  function automatic logic [GW-1:0] noiseGrid();
    logic [GW-1:0] g = '0;
    for (int i = 0; i < GW; i++) g[i] = 1'($urandom_range(0, 1));
    return g;
  endfunction

  function automatic scen_t mkScen(input int code, input int delay);
    scen_t s;
    s.grid  = rndSolGrid();
    s.uns   = 7'($urandom_range(0, 81));
    s.delay = delay;
    s.err = 1'b0; s.to = 1'b0; s.done = 1'b0; s.none = 1'b0;
    case (code)
      0: s.done = 1'b1;
      1: begin s.to = 1'b1; s.done = 1'($urandom_range(0, 1)); end
      2: begin s.err = 1'b1; s.to = 1'($urandom_range(0, 1)); s.done = 1'($urandom_range(0, 1)); end
      default: s.none = 1'b1;
    endcase
    return s;
  endfunction

  // Downstream ready pattern.
  initial begin
    out_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: clr/start pulse shape, loaded grid, drained digits and status.
  initial begin
    int clrSeq = 0;
    forever begin
      @(negedge clk);
      if (rst === 1'b0) begin
        if (clrSeq == 1) begin
          checkInt("start pulse", int'({sol_clr, sol_start, busy}), 3);
          clrSeq = 2;
        end else if (clrSeq == 2) begin
          checkInt("start end", int'({sol_clr, sol_start, busy}), 1);
          clrSeq = 0;
        end else if (sol_clr) begin
          checkInt("clr pulse", int'({sol_clr, sol_start, busy}), 5);
          if (expGrid.size() == 0) checkInt("unexpected clr", 1, 0);
          else checkGrid("in grid", sol_in_grid, expGrid.pop_front());
          clrSeq = 1;
        end
        if (out_valid && out_ready) begin
          if (expDig.size() == 0) begin
            checkInt("unexpected out digit", int'(out_digit), -1);
          end else begin
            if (drainIdx == 0) begin
              if (expRes.size() == 0) checkInt("result missing", int'(result), -1);
              else begin
                checkInt("result", int'(result), expRes.pop_front());
                checkInt("unsolved", int'(unsolved), expUns.pop_front());
              end
            end
            checkInt("out digit", int'(out_digit), expDig.pop_front());
            checkInt("out last", int'(out_last), (drainIdx == NC - 1) ? 1 : 0);
            drainIdx = (drainIdx == NC - 1) ? 0 : drainIdx + 1;
          end
        end
      end
    end
  end

  // Solver responder: presents completion status and the solved grid.
  initial begin
    scen_t s;
    int lat;
    sol_done = 1'b0; sol_timeout = 1'b0; sol_error = 1'b0;
    sol_out_grid = '0; sol_unsolved = '0;
    forever begin
      @(negedge clk);
      if (sol_start === 1'b1 && rst === 1'b0) begin
        if (scenQ.size() == 0) begin
          checkInt("unexpected start", 1, 0);
        end else begin
          s = scenQ.pop_front();
          lat = 0;
          while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            sol_error = 1'b0; sol_timeout = 1'b0; sol_done = 1'b0;
            if (s.none || lat == s.delay) begin
              sol_out_grid = s.grid;
              sol_unsolved = s.uns;
            end else begin
              sol_out_grid = noiseGrid();
              sol_unsolved = 7'($urandom_range(0, 127));
            end
            if (!s.none && lat == s.delay) begin
              sol_error = s.err; sol_timeout = s.to; sol_done = s.done;
            end
            @(negedge clk);
            lat++;
          end
          checkInt("wait latency", lat, s.none ? WD + 1 : s.delay + 2);
          sol_error = 1'b0; sol_timeout = 1'b0; sol_done = 1'b0;
          sol_out_grid = noiseGrid();
        end
      end
    end
  end

  task automatic doReset(input string tag);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkInt({tag, " outputs"},
             int'({in_ready, sol_clr, sol_start, out_valid, out_digit, out_last,
                   result, unsolved, bad_input, busy}), 0);
    checkGrid({tag, " grid"}, sol_in_grid, {GW{1'b1}});
    @(posedge clk); #1;
    rst = 1'b0;
    expDig.delete();
    drainIdx = 0;
    @(posedge clk); #1;
  endtask

  task automatic sendDigits(input int d[NC], input int n, output bit anyBad);
    int t;
    int gap;
    anyBad = 1'b0;
    for (int i = 0; i < n; i++) begin
      gap = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      in_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
        // Completion inputs toggle freely while loading; they must be ignored.
        sol_error   = 1'($urandom_range(0, 1));
        sol_timeout = 1'($urandom_range(0, 1));
        sol_done    = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
      end
      in_valid = 1'b1;
      in_digit = 4'(d[i]);
      t = 0;
      @(negedge clk);
      while (!in_ready && t < 50) begin
        @(negedge clk);
        t++;
      end
      if (!in_ready) begin
        checkInt("in_ready timeout", 0, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
      if (d[i] > 9) anyBad = 1'b1;
      if (i == 0) checkInt("bad_input first", int'(bad_input), (d[0] > 9) ? 1 : 0);
    end
    in_valid = 1'b0;
    sol_error = 1'b0; sol_timeout = 1'b0; sol_done = 1'b0;
  endtask

  task automatic runTxn(input int d[NC], input scen_t s, input int rmode, input int abortAfter);
    logic [GW-1:0] g;
    bit anyBad;
    int t;
    g = '0;
    for (int k = 0; k < NC; k++) g[k*9 +: 9] = encCell(d[k]);
    expGrid.push_back(g);
    if (s.err)       expRes.push_back(2);
    else if (s.to)   expRes.push_back(1);
    else if (s.done) expRes.push_back(0);
    else             expRes.push_back(3);
    expUns.push_back(int'(s.uns));
    for (int k = 0; k < NC; k++) expDig.push_back(decCell(s.grid[k*9 +: 9]));
    scenQ.push_back(s);
    readyMode = rmode;
    sendDigits(d, NC, anyBad);
    checkInt("bad_input end", int'(bad_input), int'(anyBad));
    t = 0;
    while (t < 3000 && ((abortAfter > 0) ? (expDig.size() > NC - abortAfter)
                                         : (expDig.size() != 0 || out_valid))) begin
      @(negedge clk);
      t++;
    end
    if (t >= 3000) checkInt("drain timeout", t, 0);
    @(posedge clk); #1;
    if (abortAfter > 0) doReset("drain reset");
    else checkGrid("grid hold", sol_in_grid, g);
  endtask

  initial begin
    bit dummyBad;
    rst = 1'b1;
    in_valid = 1'b0;
    in_digit = 4'd0;
    doReset("reset");

    // All-empty puzzle, solved grid repeating 1..9.
    for (int k = 0; k < NC; k++) digs[k] = 0;
    sc = mkScen(0, 3);
    sc.grid = cyclicGrid();
    runTxn(digs, sc, 0, 0);

    // Single given 5 in cell 0.
    digs[0] = 5;
    sc = mkScen(0, 0);
    runTxn(digs, sc, 2, 0);

    // Illegal digit in cell 40.
    for (int k = 0; k < NC; k++) digs[k] = int'($urandom_range(0, 9));
    digs[40] = 12;
    sc = mkScen(1, 5);
    runTxn(digs, sc, 0, 0);

    // Legal load clears bad_input; error and timeout together.
    for (int k = 0; k < NC; k++) digs[k] = int'($urandom_range(0, 9));
    sc = mkScen(2, 2);
    sc.to = 1'b1;
    runTxn(digs, sc, 1, 0);

    // No completion: watchdog fires.
    sc = mkScen(3, 0);
    runTxn(digs, sc, 0, 0);

    // Toggling ready; a two-bit cell and an empty cell decode to 0.
    for (int k = 0; k < NC; k++) digs[k] = int'($urandom_range(0, 15));
    sc = mkScen(0, 7);
    sc.grid[3*9 +: 9]  = 9'h003;
    sc.grid[10*9 +: 9] = 9'h000;
    runTxn(digs, sc, 1, 0);

    // Reset after 40 digits, then a clean full load.
    for (int k = 0; k < NC; k++) digs[k] = int'($urandom_range(1, 9));
    sendDigits(digs, 40, dummyBad);
    doReset("load reset");
    sc = mkScen(0, 1);
    runTxn(digs, sc, 2, 0);

    // Reset in the middle of a drain, then a clean transaction.
    sc = mkScen(1, 4);
    runTxn(digs, sc, 1, 30);
    sc = mkScen(2, 6);
    runTxn(digs, sc, 0, 0);

    // Random transactions.
    for (int r = 0; r < 6; r++) begin
      for (int k = 0; k < NC; k++) digs[k] = int'($urandom_range(0, 15));
      sc = mkScen(int'($urandom_range(0, 3)), int'($urandom_range(0, 10)));
      runTxn(digs, sc, int'($urandom_range(0, 2)), 0);
    end

    if (expDig.size() != 0 || expGrid.size() != 0 || scenQ.size() != 0)
      checkInt("leftover expectations", expDig.size() + expGrid.size() + scenQ.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global timeout: got %0d checks, expected run to complete", checks);
    $fatal(1, "simulation timeout");
  end

endmodule
